// File: rtl/gpr_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency
// returns queue in order and drain in primary-idle cycles.
//
// Ports:
//   Clk, Rst                  clock, async active-high reset
//   p_we/p_addr/p_data        primary writeback (no backpressure)
//   s_valid/s_ready/s_addr/s_data  secondary return channel (handshake)
//   gpr_we/gpr_a3/gpr_wd      register file write port
//   q_count                   occupied queue entries (valid or killed)
//   pend_mask                 registers targeted by valid queued entries
//   drop_cnt                  saturating count of killed secondary writes
module gpr_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   p_we,
    input  logic [AW-1:0]          p_addr,
    input  logic [DW-1:0]          p_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [AW-1:0]          s_addr,
    input  logic [DW-1:0]          s_data,
    output logic                   gpr_we,
    output logic [AW-1:0]          gpr_a3,
    output logic [DW-1:0]          gpr_wd,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [31:0]            pend_mask,
    output logic [7:0]             drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          r_valid [DEPTH];
    logic [AW-1:0] r_addr  [DEPTH];
    logic [DW-1:0] r_data  [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [7:0]    r_drop;

    logic             w_pact;
    logic             w_push;
    logic             w_pop;
    logic             w_head_v;
    logic             w_in_kill;
    logic [DEPTH-1:0] w_kill;
    logic [CW:0]      w_nkill;
    logic [8:0]       w_dsum;
    logic [7:0]       w_drop_nxt;
    logic [31:0]      w_pend;

    // Primary to r0 is a no-op and must not block draining.
    assign w_pact    = p_we && (p_addr != '0);
    assign s_ready   = !Rst && (r_count < FULL);
    assign w_push    = s_valid && s_ready && (s_addr != '0);
    assign w_pop     = !w_pact && (r_count != '0);
    assign w_head_v  = r_valid[r_head];
    // Incoming secondary is older than a same-cycle primary to the same reg.
    assign w_in_kill = w_pact && (s_addr == p_addr);

    always_comb begin
        w_kill  = '0;
        w_nkill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pact && r_valid[i] && (r_addr[i] == p_addr)) begin
                w_kill[i] = 1'b1;
                w_nkill   = w_nkill + (CW+1)'(1);
            end
        end
        if (w_push && w_in_kill) begin
            w_nkill = w_nkill + (CW+1)'(1);
        end
    end

    assign w_dsum     = {1'b0, r_drop} + 9'(w_nkill);
    assign w_drop_nxt = w_dsum[8] ? 8'hFF : w_dsum[7:0];

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                w_pend[r_addr[i]] = 1'b1;
            end
        end
        w_pend[0] = 1'b0;
    end

    always_comb begin
        gpr_we = 1'b0;
        gpr_a3 = '0;
        gpr_wd = '0;
        if (!Rst) begin
            if (w_pact) begin
                gpr_we = 1'b1;
                gpr_a3 = p_addr;
                gpr_wd = p_data;
            end else if (w_pop && w_head_v) begin
                gpr_we = 1'b1;
                gpr_a3 = r_addr[r_head];
                gpr_wd = r_data[r_head];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            // Head and tail differ whenever both move (push needs non-full).
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= !w_in_kill;
                r_addr[r_tail]  <= s_addr;
                r_data[r_tail]  <= s_data;
                r_tail          <= r_tail + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_drop <= w_drop_nxt;
        end
    end

    assign q_count   = r_count;
    assign pend_mask = w_pend;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: expected port writes are queued
// as stimulus is driven and popped whenever the DUT asserts gpr_we.
module tb_gpr_wb_arbiter;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        gpr_we;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wd;
    logic [1:0]  q_count;
    logic [31:0] pend_mask;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int fails  = 0;

    logic [36:0] sb[$];
    logic [31:0] rf [32];

    gpr_wb_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_addr(s_addr), .s_data(s_data),
        .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd),
        .q_count(q_count), .pend_mask(pend_mask), .drop_cnt(drop_cnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (gpr_we) rf[gpr_a3] <= gpr_wd;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst && gpr_we) begin
            checks++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_extra observed=%0h expected=none",
                       {gpr_a3, gpr_wd});
            end
            if (sb.size() != 0) chk("gpr_port", {gpr_a3, gpr_wd}, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic prim(input logic we, input logic [4:0] a,
                        input logic [31:0] d);
        p_we = we; p_addr = a; p_data = d;
    endtask

    task automatic sec(input logic v, input logic [4:0] a,
                       input logic [31:0] d);
        s_valid = v; s_addr = a; s_data = d;
    endtask

    initial begin
        Rst = 1'b1;
        prim(0, 0, 0);
        sec(0, 0, 0);
        #2;
        chk("rst_qcount", 64'(q_count), 0);
        chk("rst_pend", 64'(pend_mask), 0);
        chk("rst_drop", 64'(drop_cnt), 0);
        chk("rst_we", 64'(gpr_we), 0);
        chk("rst_ready", 64'(s_ready), 0);
        tick();
        Rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(s_ready), 1);

        // drain in order
        sec(1, 5, 32'h11); sb.push_back({5'd5, 32'h11});
        tick();
        sec(1, 6, 32'h22); sb.push_back({5'd6, 32'h22});
        #1;
        chk("drain_pend5", 64'(pend_mask), 64'h20);
        chk("drain_q1", 64'(q_count), 1);
        chk("drain_we1", 64'(gpr_we), 1);
        tick();
        sec(0, 0, 0);
        #1;
        chk("drain_pend6", 64'(pend_mask), 64'h40);
        chk("drain_q1b", 64'(q_count), 1);
        tick();
        #1;
        chk("drain_pend0", 64'(pend_mask), 0);
        chk("drain_q0", 64'(q_count), 0);
        chk("drain_idle", 64'(gpr_we), 0);

        // backpressure under continuous primary writes
        prim(1, 3, 32'hAA); sec(1, 10, 32'h33); sb.push_back({5'd3, 32'hAA});
        tick();
        sec(1, 11, 32'h44); sb.push_back({5'd3, 32'hAA});
        #1;
        chk("bp_q1", 64'(q_count), 1);
        chk("bp_rdy1", 64'(s_ready), 1);
        tick();
        sec(1, 12, 32'h55); sb.push_back({5'd3, 32'hAA});
        #1;
        chk("bp_full_rdy", 64'(s_ready), 0);
        chk("bp_q2", 64'(q_count), 2);
        chk("bp_pend", 64'(pend_mask), 64'hC00);
        tick();
        sb.push_back({5'd3, 32'hAA});
        #1;
        chk("bp_hold_q", 64'(q_count), 2);
        chk("bp_hold_rdy", 64'(s_ready), 0);
        tick();
        prim(0, 0, 0); sb.push_back({5'd10, 32'h33});
        #1;
        chk("bp_drain_a3", 64'(gpr_a3), 10);
        tick();
        sb.push_back({5'd11, 32'h44});
        #1;
        chk("bp_rdy_again", 64'(s_ready), 1);
        tick();
        sec(0, 0, 0); sb.push_back({5'd12, 32'h55});
        #1;
        chk("bp_q_last", 64'(q_count), 1);
        tick();
        #1;
        chk("bp_q0", 64'(q_count), 0);

        // kill of a queued entry
        sec(1, 7, 32'hBEEF);
        tick();
        sec(0, 0, 0); prim(1, 7, 32'h1234); sb.push_back({5'd7, 32'h1234});
        #1;
        chk("kill_pend_pre", 64'(pend_mask), 64'h80);
        tick();
        prim(0, 0, 0);
        #1;
        chk("kill_drop", 64'(drop_cnt), 1);
        chk("kill_pend", 64'(pend_mask), 0);
        chk("kill_q", 64'(q_count), 1);
        chk("kill_pop_we", 64'(gpr_we), 0);
        tick();
        #1;
        chk("kill_q0", 64'(q_count), 0);
        chk("kill_rf7", 64'(rf[7]), 32'h1234);

        // same-cycle kill
        sec(1, 9, 32'h1); prim(1, 9, 32'h2); sb.push_back({5'd9, 32'h2});
        tick();
        sec(0, 0, 0); prim(0, 0, 0);
        #1;
        chk("same_drop", 64'(drop_cnt), 2);
        chk("same_q", 64'(q_count), 1);
        chk("same_pend", 64'(pend_mask), 0);
        chk("same_we", 64'(gpr_we), 0);
        tick();
        #1;
        chk("same_q0", 64'(q_count), 0);
        chk("same_rf9", 64'(rf[9]), 2);

        // zero register on both sources
        sec(1, 0, 32'hFF);
        tick();
        sec(1, 13, 32'h66);
        #1;
        chk("zero_q", 64'(q_count), 0);
        chk("zero_drop", 64'(drop_cnt), 2);
        tick();
        sec(0, 0, 0); prim(1, 0, 32'h77); sb.push_back({5'd13, 32'h66});
        #1;
        chk("zero_p_idle_we", 64'(gpr_we), 1);
        chk("zero_p_idle_a3", 64'(gpr_a3), 13);
        tick();
        prim(0, 0, 0);
        #1;
        chk("zero_q0", 64'(q_count), 0);

        // async reset with two valid entries queued
        prim(1, 3, 32'hAA); sec(1, 20, 32'hA1); sb.push_back({5'd3, 32'hAA});
        tick();
        sec(1, 21, 32'hA2); sb.push_back({5'd3, 32'hAA});
        tick();
        prim(0, 0, 0); sec(0, 0, 0);
        chk("pre_rst_q", 64'(q_count), 2);
        chk("pre_rst_pend", 64'(pend_mask), 64'h0030_0000);
        Rst = 1'b1;
        #1;
        chk("mid_rst_q", 64'(q_count), 0);
        chk("mid_rst_pend", 64'(pend_mask), 0);
        chk("mid_rst_we", 64'(gpr_we), 0);
        chk("mid_rst_drop", 64'(drop_cnt), 0);
        chk("mid_rst_rdy", 64'(s_ready), 0);
        tick();
        Rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(s_ready), 1);
        chk("post_rst_q", 64'(q_count), 0);
        tick();
        chk("post_rst_we", 64'(gpr_we), 0);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
